// File: rtl/conv1_img_streamer.sv
// conv1_img_streamer: raster-order image RAM reader feeding the conv1 window buffer with gapless pixels.
// Optional pixel checksum accumulator enabled by defining CONV1_STREAM_CHECKSUM_EN.
module conv1_img_streamer #(
   parameter int WIDTH         = 28,
   parameter int HEIGHT        = 28,
   parameter int DATA_BITS     = 8,
   parameter int ADDR_BITS     = 10,
   parameter int IDX_BITS      = 5,
   parameter int TAIL_CYCLES   = 28,
   parameter int CHECKSUM_BITS = 18
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     mem_rd_en,
   output logic [ADDR_BITS-1:0]     mem_addr,
   input  logic [DATA_BITS-1:0]     mem_rdata,
   output logic [DATA_BITS-1:0]     data_out,
   output logic                     valid_out,
   output logic                     buf_rst_n,
   output logic [IDX_BITS-1:0]      row_idx,
   output logic [IDX_BITS-1:0]      col_idx,
   output logic                     busy,
   output logic                     frame_done,
   output logic [CHECKSUM_BITS-1:0] checksum
);
   localparam int NPIX = WIDTH * HEIGHT;
   localparam int TCW  = TAIL_CYCLES > 1 ? $clog2(TAIL_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, FETCH, STREAM, TAIL} state_t;
   state_t state, state_nxt;
   logic rd_vld;
   logic [TCW-1:0] tail_cnt;
   logic accept, last_addr, tail_last, col_last;
   assign accept    = state == IDLE && start;
   assign last_addr = mem_addr == ADDR_BITS'(NPIX - 1);
   assign tail_last = tail_cnt == TCW'(TAIL_CYCLES - 1);
   assign col_last  = col_idx == IDX_BITS'(WIDTH - 1);
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? FETCH : IDLE;
         FETCH:   state_nxt = STREAM;
         // the last pixel is on data_out when nothing more is arriving from the RAM
         STREAM:  state_nxt = (valid_out && !rd_vld) ? (TAIL_CYCLES == 0 ? IDLE : TAIL) : STREAM;
         TAIL:    state_nxt = tail_last ? IDLE : TAIL;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         rd_vld     <= 1'b0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         row_idx    <= '0;
         col_idx    <= '0;
         buf_rst_n  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         tail_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         mem_rd_en  <= accept || (mem_rd_en && !last_addr);
         mem_addr   <= accept ? '0 : (mem_rd_en && !last_addr) ? mem_addr + 1'b1 : mem_addr;
         rd_vld     <= mem_rd_en;
         data_out   <= rd_vld ? mem_rdata : '0;
         valid_out  <= rd_vld;
         if (rd_vld) begin
            col_idx <= (!valid_out || col_last) ? '0 : col_idx + 1'b1;
            row_idx <= !valid_out ? '0 : col_last ? row_idx + 1'b1 : row_idx;
         end
         buf_rst_n  <= rd_vld || state_nxt == TAIL;
         busy       <= state_nxt != IDLE;
         frame_done <= state != IDLE && state_nxt == IDLE;
         tail_cnt   <= state == TAIL ? tail_cnt + 1'b1 : '0;
      end
   end
`ifdef CONV1_STREAM_CHECKSUM_EN
   // accumulated from the RAM side so the sum tracks data_out cycle for cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         checksum <= '0;
      else
         checksum <= accept ? '0 : rd_vld ? checksum + CHECKSUM_BITS'(mem_rdata) : checksum;
   end
`else
   assign checksum = '0;
`endif
endmodule

// File: tb/tb_conv1_img_streamer.sv
// tb_conv1_img_streamer: randomized frame checks of conv1_img_streamer against a cycle-indexed reference model.
module tb_conv1_img_streamer;
   localparam int W = 28, H = 28, N = W * H, TL = 28, CB = 18;
   logic clk = 0, rst_n = 1, start = 0, s_start = 0;
   logic mem_rd_en, valid_out, buf_rst_n, busy, frame_done;
   logic [9:0] mem_addr;
   logic [7:0] mem_rdata, data_out;
   logic [4:0] row_idx, col_idx;
   logic [CB-1:0] checksum;
   logic s_rd_en, s_valid, s_buf, s_busy, s_done;
   logic [5:0] s_addr;
   logic [7:0] s_rdata, s_data;
   logic [2:0] s_row, s_col;
   logic [CB-1:0] s_sum;
   logic [7:0] ram [1024];
   int vectors = 0, miscompares = 0;

   conv1_img_streamer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .data_out(data_out), .valid_out(valid_out), .buf_rst_n(buf_rst_n),
      .row_idx(row_idx), .col_idx(col_idx), .busy(busy), .frame_done(frame_done), .checksum(checksum));

   conv1_img_streamer #(.WIDTH(6), .HEIGHT(6), .TAIL_CYCLES(2), .ADDR_BITS(6), .IDX_BITS(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .mem_rd_en(s_rd_en), .mem_addr(s_addr),
      .mem_rdata(s_rdata), .data_out(s_data), .valid_out(s_valid), .buf_rst_n(s_buf),
      .row_idx(s_row), .col_idx(s_col), .busy(s_busy), .frame_done(s_done), .checksum(s_sum));

   always #5 clk = ~clk;
   always_ff @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];
   always_ff @(posedge clk) if (s_rd_en) s_rdata <= {2'b00, s_addr};

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_sum();
      int s = 0;
      for (int k = 0; k < N; k++) s += ram[k];
`ifdef CONV1_STREAM_CHECKSUM_EN
      return s % (1 << CB);
`else
      return 0;
`endif
   endfunction

   task automatic check_zero(input string where);
      check({where, " rd_en"}, int'(mem_rd_en), 0);
      check({where, " addr"}, int'(mem_addr), 0);
      check({where, " data"}, int'(data_out), 0);
      check({where, " valid"}, int'(valid_out), 0);
      check({where, " buf_rst_n"}, int'(buf_rst_n), 0);
      check({where, " row"}, int'(row_idx), 0);
      check({where, " col"}, int'(col_idx), 0);
      check({where, " busy"}, int'(busy), 0);
      check({where, " done"}, int'(frame_done), 0);
      check({where, " sum"}, int'(checksum), 0);
   endtask

   // Entered at a negedge with the DUT idle (or in its frame_done cycle when chained)
   task automatic run_frame(input int poke_at, input bit hold, input int abort_at);
      int s = exp_sum();
      bit pix;
      start = 1;
      @(posedge clk);
      for (int j = 1; j <= N + TL + 3; j++) begin
         @(negedge clk);
         start = hold || (j == poke_at);
         if (j == abort_at) begin
            rst_n = 0;
            #1 check_zero("async_rst");
            repeat (20) begin
               @(negedge clk);
               check("rst_done", int'(frame_done), 0);
               check("rst_buf", int'(buf_rst_n), 0);
            end
            rst_n = 1;
            repeat (5) begin
               @(negedge clk);
               check("post_rst_done", int'(frame_done), 0);
               check("post_rst_busy", int'(busy), 0);
            end
            return;
         end
         pix = j >= 3 && j <= N + 2;
         check($sformatf("rd_en@%0d", j), int'(mem_rd_en), int'(j <= N));
         if (j <= N) check($sformatf("addr@%0d", j), int'(mem_addr), j - 1);
         check($sformatf("valid@%0d", j), int'(valid_out), int'(pix));
         check($sformatf("data@%0d", j), int'(data_out), pix ? int'(ram[j-3]) : 0);
         if (pix) begin
            check($sformatf("row@%0d", j), int'(row_idx), (j - 3) / W);
            check($sformatf("col@%0d", j), int'(col_idx), (j - 3) % W);
         end
         check($sformatf("buf_rst_n@%0d", j), int'(buf_rst_n), int'(j >= 3 && j <= N + 2 + TL));
         check($sformatf("busy@%0d", j), int'(busy), int'(j <= N + 2 + TL));
         check($sformatf("done@%0d", j), int'(frame_done), int'(j == N + 3 + TL));
         if (j == N + 2 || j == N + 3 + TL) check($sformatf("sum@%0d", j), int'(checksum), s);
      end
   endtask

   initial begin
      int nv, nb, done_at;
      #2 rst_n = 0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 1024; k++) ram[k] = 8'(k % 256);
      run_frame(0, 0, 0);
`ifdef CONV1_STREAM_CHECKSUM_EN
      check("sum_ramp", int'(checksum), 98040);
`else
      check("sum_ramp", int'(checksum), 0);
`endif
      check("end_row", int'(row_idx), 27);
      check("end_col", int'(col_idx), 27);
      repeat (4) @(negedge clk);
      for (int k = 0; k < N; k++) ram[k] = 8'($urandom);
      run_frame(100, 1, 0);
      run_frame($urandom_range(20, 700), 0, 0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++) ram[k] = 8'($urandom);
      run_frame(0, 0, 403);
      for (int k = 0; k < N; k++) ram[k] = 8'($urandom);
      run_frame(0, 0, 0);
      repeat (2) @(negedge clk);
      nv = 0; nb = 0; done_at = -1;
      s_start = 1;
      @(posedge clk);
      for (int j = 1; j <= 50; j++) begin
         @(negedge clk);
         s_start = 0;
         if (s_valid) begin
            check($sformatf("s_data@%0d", j), int'(s_data), nv);
            check($sformatf("s_col@%0d", j), int'(s_col), nv % 6);
            check($sformatf("s_row@%0d", j), int'(s_row), nv / 6);
            nv++;
         end
         if (s_buf) nb++;
         if (s_done && done_at < 0) done_at = j;
      end
      check("s_valid_count", nv, 36);
      check("s_buf_cycles", nb, 38);
      check("s_done_at", done_at, 41);
`ifdef CONV1_STREAM_CHECKSUM_EN
      check("s_sum", int'(s_sum), 630);
`else
      check("s_sum", int'(s_sum), 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
